// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, iteration count and FSM encoding for the sequential divider
package div_pkg;

    localparam int DIV_W    = 8;
    localparam int DIV_ITER = 8;

    // 2'b11 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // A trial subtraction succeeds when the shifted partial remainder overflowed
    // eight bits or the 8-bit subtraction produced no borrow.
    function automatic logic trial_ge(input logic r_msb, input logic no_borrow);
        return r_msb | no_borrow;
    endfunction

endpackage

// File: rtl/seq_divider8_if.sv
// rtl/seq_divider8_if.sv - start/done request and result bundle of the sequential divider
interface seq_divider8_if #(
    parameter int W = div_pkg::DIV_W
);

    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/adder.sv
// rtl/adder.sv - ripple-carry add/subtract unit; sub inverts b, cin supplies the +1
module adder #(
    parameter int W = div_pkg::DIV_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] b_eff;
    logic         carry;

    // Bit-serial carry chain built from full-adder equations.
    always_comb begin
        b_eff = b ^ {W{sub}};
        carry = cin;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ carry;
            carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_divider8.sv
// rtl/seq_divider8.sv - 8-bit unsigned restoring divider, one quotient bit per clock
module seq_divider8 #(
    parameter int DIV_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider8_if.slave bus
);

    import div_pkg::*;

    div_state_e       state_q, state_d;
    logic [DIV_W-1:0] q_q, q_d;          // dividend shifting out / quotient shifting in
    logic [DIV_W-1:0] dvs_q, dvs_d;      // captured divisor
    logic [DIV_W-1:0] r_q, r_d;          // partial remainder, always < divisor between steps
    logic [2:0]       count_q, count_d;
    logic [DIV_W-1:0] quot_q, quot_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // The stored remainder never exceeds eight bits; only the shifted
    // value needs the ninth bit, so that is where the width lives.
    logic [DIV_W:0]   r_shift;
    logic [DIV_W-1:0] diff;
    logic             no_borrow;
    logic             ge;
    logic [DIV_W-1:0] r_next;
    logic [DIV_W-1:0] q_next;

    // Shift the next dividend bit into the partial remainder.
    always_comb begin
        r_shift = {r_q, q_q[DIV_W-1]};
    end

    adder #(.W(DIV_W)) u_sub (
        .a    (r_shift[DIV_W-1:0]),
        .b    (dvs_q),
        .sub  (1'b1),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // Restoring step: keep the difference when the trial subtraction fits.
    always_comb begin
        ge     = trial_ge(r_shift[DIV_W], no_borrow);
        r_next = ge ? diff : r_shift[DIV_W-1:0];
        q_next = {q_q[DIV_W-2:0], ge};
    end

    // Next-state and datapath load selection.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    q_d     = bus.dividend;
                    dvs_d   = bus.divisor;
                    r_d     = '0;
                    count_d = '0;
                    if (bus.divisor == '0) begin
                        // No iterations: publish the saturated result right away.
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_d     = r_next;
                q_d     = q_next;
                count_d = count_q + 3'd1;
                if (count_q == 3'(DIV_ITER - 1)) begin
                    state_d = ST_DONE;
                    quot_d  = q_next;
                    rem_d   = r_next;
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule
